data_mem_ctrl: RTL and testbench

- Data-memory responder for the ramR/ramW load/store requests issued by the core's instruction decoder.
- Holds a word-organised, byte-enabled data RAM.
- Performs lb/lh/lw/lbu/lhu/sb/sh/sw, with the access width selected by the instruction's funct3.
- Returns sign- or zero-extended load data, and drives a stall so the core holds the current instruction until the access completes.

---
 rtl/data_mem_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
`default_nettype none
//============================================================================
// Module      : data_mem_ctrl
// Description : Byte-enabled data RAM responder for core load/store requests
//               (lb/lh/lw/lbu/lhu/sb/sh/sw) with stall/done/err handshake.
// Revision    : 1.0 - initial release
//============================================================================
module data_mem_ctrl #(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = 8
) (
    input  logic        clock,
    input  logic        nReset,
    input  logic        ramR,
    input  logic        ramW,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_WAIT = 2'd1,
        STORE     = 2'd2,
        RESP      = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [31:0]        r_mem [DEPTH_WORDS];
    logic [IDX_W-1:0]   r_idx;
    logic [1:0]         r_off;
    logic [2:0]         r_f3;
    logic [31:0]        r_wdata;
    logic [31:0]        r_rdata;
    logic               r_err;

    logic               w_req;
    logic               w_f3_load_ok;
    logic               w_f3_store_ok;
    logic               w_align_ok;
    logic               w_legal;
    logic               w_illegal;
    logic               w_accept;
    logic [3:0]         w_be;
    logic [31:0]        w_wlanes;
    logic [31:0]        w_word;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [31:0]        w_load_ext;
    logic               w_unused_addr;

    // Upper address bits alias onto the RAM and are intentionally dropped.
    assign w_unused_addr = ^addr[31:IDX_W+2];

    // ---------------------------------------------------------------
    // Request legality
    // ---------------------------------------------------------------
    always_comb begin
        w_f3_load_ok  = 1'b0;
        w_f3_store_ok = 1'b0;
        w_align_ok    = 1'b1;
        case (funct3)
            c_F3_B, c_F3_H, c_F3_W: begin
                w_f3_load_ok  = 1'b1;
                w_f3_store_ok = 1'b1;
            end
            c_F3_BU, c_F3_HU: w_f3_load_ok = 1'b1;
            default: ;
        endcase
        case (funct3[1:0])
            2'b01:   w_align_ok = ~addr[0];
            2'b10:   w_align_ok = (addr[1:0] == 2'b00);
            default: w_align_ok = 1'b1;
        endcase
    end

    assign w_req     = ramR | ramW;
    assign w_legal   = ~(ramR & ramW) & w_align_ok &
                       ((ramR & w_f3_load_ok) | (ramW & w_f3_store_ok));
    assign w_illegal = w_req & ~w_legal;
    assign w_accept  = (r_state == IDLE) & w_legal;

    // ---------------------------------------------------------------
    // Next state and handshake outputs
    // ---------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        stall  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_legal) begin
                    stall  = 1'b1;
                    w_next = ramR ? LOAD_WAIT : STORE;
                end
            end
            LOAD_WAIT: begin
                stall  = 1'b1;
                w_next = RESP;
            end
            STORE: begin
                stall  = 1'b1;
                w_next = RESP;
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign done  = (r_state == RESP);
    assign err   = r_err;
    assign rdata = r_rdata;

    // ---------------------------------------------------------------
    // Load data selection and extension
    // ---------------------------------------------------------------
    assign w_word = r_mem[r_idx];

    always_comb begin
        w_byte     = w_word[8*r_off +: 8];
        w_half     = r_off[1] ? w_word[31:16] : w_word[15:0];
        w_load_ext = w_word;
        case (r_f3)
            c_F3_B:  w_load_ext = {{24{w_byte[7]}}, w_byte};
            c_F3_BU: w_load_ext = {24'd0, w_byte};
            c_F3_H:  w_load_ext = {{16{w_half[15]}}, w_half};
            c_F3_HU: w_load_ext = {16'd0, w_half};
            default: w_load_ext = w_word;
        endcase
    end

    // ---------------------------------------------------------------
    // Store lane enables; data is replicated so every lane sees its byte
    // ---------------------------------------------------------------
    always_comb begin
        w_be     = 4'b0000;
        w_wlanes = r_wdata;
        case (r_f3)
            c_F3_B: begin
                w_be           = 4'b0000;
                w_be[r_off]    = 1'b1;
                w_wlanes       = {4{r_wdata[7:0]}};
            end
            c_F3_H: begin
                w_be     = r_off[1] ? 4'b1100 : 4'b0011;
                w_wlanes = {2{r_wdata[15:0]}};
            end
            default: begin
                w_be     = 4'b1111;
                w_wlanes = r_wdata;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Control state
    // ---------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!nReset) begin
            r_state <= IDLE;
            r_err   <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            r_state <= w_next;
            r_err   <= (r_state == IDLE) & w_illegal;
            if (r_state == LOAD_WAIT) begin
                r_rdata <= w_load_ext;
            end
        end
    end

    // Request fields captured on acceptance; no reset needed on the datapath.
    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_idx   <= addr[IDX_W+1:2];
            r_off   <= addr[1:0];
            r_f3    <= funct3;
            r_wdata <= wdata;
        end
    end

    // Reset wins over an in-flight store.
    always_ff @(posedge clock) begin
        if (nReset && (r_state == STORE)) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[r_idx][8*i +: 8] <= w_wlanes[8*i +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
//============================================================================
// Module      : tb_data_mem_ctrl
// Description : Scoreboard testbench for data_mem_ctrl load/store responder.
// Revision    : 1.0 - initial release
//============================================================================
module tb_data_mem_ctrl;

    localparam int K_DONE  = 0;
    localparam int K_ERR   = 1;
    localparam int K_PROBE = 2;

    typedef struct {
        int          kind;
        int          stalls;
        logic [31:0] rd;
        string       name;
    } exp_t;

    logic        clock;
    logic        nReset;
    logic        ramR;
    logic        ramW;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        done;
    logic        err;

    logic        probe;
    logic        mon_en;
    logic [31:0] last_rd;
    exp_t        sb[$];
    int          tests;
    int          fails;

    data_mem_ctrl #(.DEPTH_WORDS(256), .IDX_W(8)) dut (
        .clock  (clock),
        .nReset (nReset),
        .ramR   (ramR),
        .ramW   (ramW),
        .funct3 (funct3),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .stall  (stall),
        .done   (done),
        .err    (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Issue one request and hold it the way the core does: until stall drops.
    task automatic req(input logic r, input logic w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int kind, input logic [31:0] exp_rd, input string nm);
        exp_t e;
        e.kind   = kind;
        e.stalls = (kind == K_DONE) ? 2 : 0;
        e.rd     = exp_rd;
        e.name   = nm;
        sb.push_back(e);
        @(posedge clock);
        #1;
        ramR = r; ramW = w; funct3 = f3; addr = a; wdata = wd;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (!stall) break;
        end
        @(posedge clock);
        #1;
        ramR = 1'b0; ramW = 1'b0;
    endtask

    task automatic load(input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] exp_rd, input string nm);
        req(1'b1, 1'b0, f3, a, 32'h0, K_DONE, exp_rd, nm);
        last_rd = exp_rd;
    endtask

    task automatic store(input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input string nm);
        req(1'b0, 1'b1, f3, a, wd, K_DONE, last_rd, nm);
    endtask

    task automatic bad(input logic r, input logic w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input string nm);
        req(r, w, f3, a, wd, K_ERR, last_rd, nm);
    endtask

    task automatic probe_idle(input logic [31:0] exp_rd, input string nm);
        exp_t e;
        e.kind   = K_PROBE;
        e.stalls = 0;
        e.rd     = exp_rd;
        e.name   = nm;
        sb.push_back(e);
        @(posedge clock);
        #1 probe = 1'b1;
        @(posedge clock);
        #1 probe = 1'b0;
    endtask

    // Monitor: every done/err pulse or idle probe consumes one expectation.
    initial begin
        int   stall_run;
        int   wd_cnt;
        int   got;
        exp_t e;
        stall_run = 0;
        wd_cnt    = 0;
        forever begin
            @(negedge clock);
            if (!mon_en || !nReset) begin
                stall_run = 0;
            end else begin
                if (stall) stall_run++;
                if (done || err || probe) begin
                    tests++;
                    if (sb.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_event: done=%0b err=%0b probe=%0b, required no event",
                                 done, err, probe);
                    end else begin
                        e = sb.pop_front();
                        got = (done && !err && !probe) ? K_DONE :
                              (err && !done && !probe) ? K_ERR  :
                              (probe && !done && !err) ? K_PROBE : 3;
                        if (got != e.kind || stall_run != e.stalls || rdata !== e.rd) begin
                            fails++;
                            $display("FAIL %s: got kind=%0d stalls=%0d rdata=%08h, required kind=%0d stalls=%0d rdata=%08h",
                                     e.name, got, stall_run, rdata, e.kind, e.stalls, e.rd);
                        end
                    end
                    stall_run = 0;
                    wd_cnt    = 0;
                end else if (sb.size() != 0) begin
                    wd_cnt++;
                    if (wd_cnt > 16) begin
                        e = sb.pop_front();
                        tests++;
                        fails++;
                        $display("FAIL %s: no response within 16 cycles, required kind=%0d", e.name, e.kind);
                        wd_cnt = 0;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tests   = 0;
        fails   = 0;
        nReset  = 1'b0;
        ramR    = 1'b0;
        ramW    = 1'b0;
        funct3  = 3'b000;
        addr    = 32'h0;
        wdata   = 32'h0;
        probe   = 1'b0;
        mon_en  = 1'b0;
        last_rd = 32'h0;
        repeat (3) @(posedge clock);
        #1;
        nReset = 1'b1;
        mon_en = 1'b1;
        probe_idle(32'h0, "reset_state");

        store(3'b010, 32'h10, 32'hDEADBEEF, "sw_10");
        load (3'b010, 32'h10, 32'hDEADBEEF, "lw_10");
        load (3'b000, 32'h13, 32'hFFFFFFDE, "lb_13");
        load (3'b100, 32'h13, 32'h000000DE, "lbu_13");
        load (3'b001, 32'h10, 32'hFFFFBEEF, "lh_10");
        load (3'b101, 32'h12, 32'h0000DEAD, "lhu_12");
        store(3'b000, 32'h11, 32'h000000AA, "sb_11");
        load (3'b010, 32'h10, 32'hDEADAAEF, "lw_after_sb");
        store(3'b001, 32'h12, 32'h00001234, "sh_12");
        load (3'b010, 32'h10, 32'h1234AAEF, "lw_after_sh");
        load (3'b000, 32'h11, 32'hFFFFFFAA, "lb_11");
        load (3'b100, 32'h10, 32'h000000EF, "lbu_10");
        load (3'b001, 32'h12, 32'h00001234, "lh_12_pos");

        bad(1'b1, 1'b0, 3'b010, 32'h11, 32'h0,        "ill_lw_11");
        bad(1'b1, 1'b0, 3'b001, 32'h13, 32'h0,        "ill_lh_13");
        bad(1'b1, 1'b0, 3'b011, 32'h10, 32'h0,        "ill_f3_011");
        bad(1'b1, 1'b1, 3'b010, 32'h10, 32'hFFFFFFFF, "ill_r_and_w");
        bad(1'b0, 1'b1, 3'b010, 32'h12, 32'hFFFFFFFF, "ill_sw_12");
        bad(1'b0, 1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, "ill_store_f3_100");
        load(3'b010, 32'h10, 32'h1234AAEF, "lw_after_illegal");

        store(3'b010, 32'h400, 32'h00000055, "sw_alias_400");
        load (3'b010, 32'h000, 32'h00000055, "lw_alias_000");

        store(3'b010, 32'h20, 32'h00000007, "sw_20_old");
        load (3'b010, 32'h20, 32'h00000007, "lw_20_old");
        // Store of 1 to 0x20, reset asserted during its STORE cycle.
        @(posedge clock);
        #1;
        ramW = 1'b1; funct3 = 3'b010; addr = 32'h20; wdata = 32'h1;
        @(posedge clock);
        #1;
        nReset = 1'b0;
        ramW   = 1'b0;
        @(posedge clock);
        #1;
        nReset  = 1'b1;
        last_rd = 32'h0;
        probe_idle(32'h0, "after_mid_store_reset");
        load(3'b010, 32'h20, 32'h00000007, "lw_20_after_reset");

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clock);
        repeat (3) @(posedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
